// File: rtl/piso_pkg.sv
// Shared state type and frame-length helper for the piso_serializer slice.
// Build option PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

`ifdef PISO_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

   // Number of serial bits per frame for a given data width.
   function automatic int unsigned frame_len(input int unsigned width);
      return width + PARITY_BITS;
   endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for the serializer: sync clear, enable, and decodes of
// the terminal value (LAST) and the value just before it.
module bit_counter #(
   parameter int unsigned CNT_W = 3,
   parameter int unsigned LAST  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o,
   output logic pre_tc_o
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);
   localparam logic [CNT_W-1:0] PRE_C  = CNT_W'(LAST - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o     = (count_q == LAST_C);
   assign pre_tc_o = (count_q == PRE_C);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage, MSB first, valid/ready word input, gapless back-to-back frames.
// Build option PISO_PARITY_EN adds a trailing even-parity bit; ports are identical in both builds.
module piso_serializer
   import piso_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_done
);

   localparam int unsigned FRAME_LEN = frame_len(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             ready_en_q;
   logic             accept;
   logic             advance;
   logic             cnt_clr;
   logic             cnt_tc;
   logic             cnt_pre_tc;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   bit_counter #(
      .CNT_W (CNT_W),
      .LAST  (FRAME_LEN - 1)
   ) u_bit_counter (
      .clk      (clk),
      .rst_n    (reset),
      .clr_i    (cnt_clr),
      .en_i     (advance),
      .tc_o     (cnt_tc),
      .pre_tc_o (cnt_pre_tc)
   );

   // ready_en_q holds load_ready low through reset and for the first cycle after release.
   assign load_ready = ready_en_q && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_tc));
   assign accept     = load_valid && load_ready;
   assign advance    = (state_q == SHIFT) && !cnt_tc && !accept;
   assign cnt_clr    = accept || ((state_q == SHIFT) && cnt_tc);

   // The shift register is preloaded already shifted: the MSB goes straight to ser_out on accept.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      ser_out_d    = 1'b0;
      ser_valid_d  = 1'b0;
      frame_done_d = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d     = parity_q;
`endif
      if (accept) begin
         state_d     = SHIFT;
         shreg_d     = load_data << 1;
         ser_out_d   = load_data[WIDTH-1];
         ser_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
         parity_d    = ^load_data;
`endif
      end else if (advance) begin
         shreg_d      = shreg_q << 1;
         ser_out_d    = shreg_q[WIDTH-1];
         ser_valid_d  = 1'b1;
         frame_done_d = cnt_pre_tc;
`ifdef PISO_PARITY_EN
         if (cnt_pre_tc) begin
            ser_out_d = parity_q;
         end
`endif
      end else if (state_q == SHIFT) begin
         state_d = IDLE;
      end
   end

   // NOTE: the shift register is cleared on reset so ser_out can never replay a stale word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         ser_out_q    <= 1'b0;
         ser_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         ser_out_q    <= ser_out_d;
         ser_valid_q  <= ser_valid_d;
         frame_done_q <= frame_done_d;
         ready_en_q   <= 1'b1;
      end
   end

`ifdef PISO_PARITY_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=4 frames (basic, back-to-back, busy, reset abort)
// and a WIDTH=8 instance; expected streams follow PISO_PARITY_EN when it is defined.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_valid;
   logic [3:0] load_data;
   logic       load_ready, ser_out, ser_valid, frame_done;
   logic       w8_valid;
   logic [7:0] w8_data;
   logic       w8_ready, w8_ser_out, w8_ser_valid, w8_frame_done;
   logic [3:0] sipo_q = 4'b0000;
   int         n_checks = 0;
   int         n_errors = 0;

`ifdef PISO_PARITY_EN
   localparam int         FL4      = 5;
   localparam int         FL8      = 9;
   localparam logic [3:0] SIPO_EXP = 4'b0111;
`else
   localparam int         FL4      = 4;
   localparam int         FL8      = 8;
   localparam logic [3:0] SIPO_EXP = 4'b1011;
`endif

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .frame_done (frame_done)
   );

   piso_serializer #(.WIDTH(8)) dut_w8 (
      .clk        (clk),
      .reset      (reset),
      .load_valid (w8_valid),
      .load_data  (w8_data),
      .load_ready (w8_ready),
      .ser_out    (w8_ser_out),
      .ser_valid  (w8_ser_valid),
      .frame_done (w8_frame_done)
   );

   // Downstream 4-bit serial-in/parallel-out register fed by the WIDTH=4 instance.
   always @(posedge clk) begin
      if (ser_valid) sipo_q <= {sipo_q[2:0], ser_out};
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ser_valid"},  ser_valid,  1'b0);
      check({tag, " ser_out"},    ser_out,    1'b0);
      check({tag, " frame_done"}, frame_done, 1'b0);
      check({tag, " load_ready"}, load_ready, 1'b1);
   endtask

   // Vectors are written in time order: the leftmost of len bits is the first cycle.
   // lv gives load_valid to hold for the rest of each cycle, after its checks.
   task automatic check_stream(input string tag, input logic [15:0] bits, input logic [15:0] fd,
                               input logic [15:0] rdy, input logic [15:0] lv, input int len);
      for (int i = 0; i < len; i++) begin
         int k;
         k = len - 1 - i;
         check($sformatf("%s ser_valid[%0d]", tag, i),  ser_valid,  1'b1);
         check($sformatf("%s ser_out[%0d]", tag, i),    ser_out,    bits[k]);
         check($sformatf("%s frame_done[%0d]", tag, i), frame_done, fd[k]);
         check($sformatf("%s load_ready[%0d]", tag, i), load_ready, rdy[k]);
         load_valid = lv[k];
         step();
      end
   endtask

   initial begin
      logic [8:0] exp8;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = 4'b0000;
      w8_valid   = 1'b0;
      w8_data    = 8'h00;
      @(negedge clk);
      step();
      step();

      check("reset ser_valid",  ser_valid,    1'b0);
      check("reset ser_out",    ser_out,      1'b0);
      check("reset frame_done", frame_done,   1'b0);
      check("reset load_ready", load_ready,   1'b0);
      check("reset w8 valid",   w8_ser_valid, 1'b0);
      reset = 1'b1;
      check("release cycle load_ready", load_ready, 1'b0);
      step();
      check_idle("post-reset");

      // Basic frame; load_data changes right after the accept edge.
      load_valid = 1'b1;
      load_data  = 4'b1011;
      step();
      load_valid = 1'b0;
      load_data  = 4'b0000;
`ifdef PISO_PARITY_EN
      check_stream("basic", 16'b10111, 16'b00001, 16'b00001, 16'b00000, FL4);
`else
      check_stream("basic", 16'b1011, 16'b0001, 16'b0001, 16'b0000, FL4);
`endif
      check("sipo after basic", sipo_q, SIPO_EXP);
      check_idle("after basic");

      // Back-to-back: load_valid held high across both words.
      load_valid = 1'b1;
      load_data  = 4'b1100;
      step();
      load_data  = 4'b0011;
`ifdef PISO_PARITY_EN
      check_stream("b2b", 16'b1100000110, 16'b0000100001, 16'b0000100001, 16'b1111100000, 2 * FL4);
`else
      check_stream("b2b", 16'b11000011, 16'b00010001, 16'b00010001, 16'b11110000, 2 * FL4);
`endif
      check_idle("after b2b");

      // Busy ignore: 4'b1111 offered while shifting is taken only when ready returns.
      load_valid = 1'b1;
      load_data  = 4'b0100;
      step();
      load_data  = 4'b1111;
`ifdef PISO_PARITY_EN
      check_stream("busy", 16'b0100111110, 16'b0000100001, 16'b0000100001, 16'b0111100000, 2 * FL4);
`else
      check_stream("busy", 16'b01001111, 16'b00010001, 16'b00010001, 16'b01110000, 2 * FL4);
`endif
      check_idle("after busy");

      // Odd and even popcount words.
      load_valid = 1'b1;
      load_data  = 4'b0111;
      step();
      load_valid = 1'b0;
`ifdef PISO_PARITY_EN
      check_stream("w0111", 16'b01111, 16'b00001, 16'b00001, 16'b00000, FL4);
`else
      check_stream("w0111", 16'b0111, 16'b0001, 16'b0001, 16'b0000, FL4);
`endif
      load_valid = 1'b1;
      load_data  = 4'b0110;
      step();
      load_valid = 1'b0;
`ifdef PISO_PARITY_EN
      check_stream("w0110", 16'b01100, 16'b00001, 16'b00001, 16'b00000, FL4);
`else
      check_stream("w0110", 16'b0110, 16'b0001, 16'b0001, 16'b0000, FL4);
`endif
      check_idle("after parity words");

      // Reset mid-frame, asserted while bit 2 of 4'b1010 is on ser_out.
      load_valid = 1'b1;
      load_data  = 4'b1010;
      step();
      load_valid = 1'b0;
      check("abort bit0", ser_out, 1'b1);
      step();
      check("abort bit1", ser_out, 1'b0);
      step();
      check("abort bit2", ser_out, 1'b1);
      check("abort bit2 valid", ser_valid, 1'b1);
      reset = 1'b0;
      step();
      check("abort ser_valid",  ser_valid,  1'b0);
      check("abort ser_out",    ser_out,    1'b0);
      check("abort frame_done", frame_done, 1'b0);
      check("abort load_ready", load_ready, 1'b0);
      reset = 1'b1;
      check("abort release load_ready", load_ready, 1'b0);
      step();
      check_idle("after abort");
      step();
      check_idle("after abort +1");

      // WIDTH=8 instance: 8'hA5, one-cycle idle-to-first-bit latency.
`ifdef PISO_PARITY_EN
      exp8 = {8'hA5, 1'b0};
`else
      exp8 = {1'b0, 8'hA5};
`endif
      check("w8 idle valid", w8_ser_valid, 1'b0);
      check("w8 idle ready", w8_ready,     1'b1);
      w8_valid = 1'b1;
      w8_data  = 8'hA5;
      step();
      w8_valid = 1'b0;
      w8_data  = 8'h00;
      for (int i = 0; i < FL8; i++) begin
         check($sformatf("w8 ser_valid[%0d]", i),  w8_ser_valid,  1'b1);
         check($sformatf("w8 ser_out[%0d]", i),    w8_ser_out,    exp8[FL8 - 1 - i]);
         check($sformatf("w8 frame_done[%0d]", i), w8_frame_done, (i == FL8 - 1));
         step();
      end
      check("w8 end valid",      w8_ser_valid,  1'b0);
      check("w8 end frame_done", w8_frame_done, 1'b0);
      check("w8 end ready",      w8_ready,      1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
